// File: rtl/trace_acc.sv
// ---------------------------------------------------------------------------
// trace_acc
//   Computes the trace (sum of the diagonal) of one square NxN matrix per
//   frame. Elements arrive row-major over a valid/ready input. The trace is
//   returned over a valid/ready output one clock after the last element.
//
//   Parameters
//     DW  input element width, signed
//     N   matrix dimension (>=2), a frame is N*N elements
//     OW  accumulator / output width, signed (>=DW)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      begin a new frame (IDLE, or DONE together with the out handshake)
//     clr        synchronous abort back to IDLE, partial sum dropped
//     in_valid   in_data valid
//     in_ready   high while accumulating
//     in_data    matrix element, row-major
//     out_valid  trace valid, held until accepted
//     out_ready  downstream accepts out_data
//     out_data   trace of the last complete frame
//     busy       state is not IDLE
//     sat        result was clipped (always 0 unless TRACE_SAT_EN)
//
//   Build option
//     TRACE_SAT_EN : saturating diagonal adds with a sticky per-frame sat
//                    flag. Undefined: modulo 2^OW wrap, sat tied to 0.
// ---------------------------------------------------------------------------
module trace_acc #(
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          busy,
  output logic          sat
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic [OW-1:0] acc_reg;
  logic [OW-1:0] out_data_reg;
  logic          out_valid_reg;

  logic          xfer;
  logic          on_diag;
  logic          last_elem;
  logic [OW-1:0] acc_next;

  assign in_ready  = (state_reg == ACCUM);
  assign busy      = (state_reg != IDLE);
  assign xfer      = in_valid && in_ready;
  assign on_diag   = (row_reg == col_reg);
  assign last_elem = (row_reg == LAST) && (col_reg == LAST);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

`ifdef TRACE_SAT_EN
  logic          sat_acc_reg;   // sticky clip flag for the frame in progress
  logic          sat_reg;       // flag presented alongside out_data
  logic          clip_next;
  logic [OW:0]   sum_wide;

  // One extra bit of headroom: overflow shows up as the top two bits differing.
  assign sum_wide = {acc_reg[OW-1], acc_reg} + (OW+1)'($signed(in_data));

  always_comb begin
    acc_next  = acc_reg;
    clip_next = 1'b0;
    if (on_diag) begin
      acc_next = sum_wide[OW-1:0];
      if (sum_wide[OW] != sum_wide[OW-1]) begin
        clip_next = 1'b1;
        acc_next  = sum_wide[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
    end
  end

  assign sat = sat_reg;
`else
  always_comb begin
    acc_next = acc_reg;
    if (on_diag) begin
      acc_next = acc_reg + OW'($signed(in_data));
    end
  end

  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
`ifdef TRACE_SAT_EN
      sat_acc_reg   <= 1'b0;
      sat_reg       <= 1'b0;
`endif
    end else if (clr) begin
      // Abort: out_data (and sat) keep the last delivered result.
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
`ifdef TRACE_SAT_EN
      sat_acc_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= ACCUM;
            row_reg   <= '0;
            col_reg   <= '0;
            acc_reg   <= '0;
`ifdef TRACE_SAT_EN
            sat_acc_reg <= 1'b0;
`endif
          end
        end

        ACCUM: begin
          if (xfer) begin
            acc_reg <= acc_next;
`ifdef TRACE_SAT_EN
            sat_acc_reg <= sat_acc_reg | clip_next;
`endif
            if (col_reg == LAST) begin
              col_reg <= '0;
              row_reg <= row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
            if (last_elem) begin
              // Row must wrap explicitly: N need not be a power of two.
              row_reg       <= '0;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              out_data_reg  <= acc_next;
`ifdef TRACE_SAT_EN
              sat_reg       <= sat_acc_reg | clip_next;
`endif
            end
          end
        end

        DONE: begin
          if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            if (start) begin
              // Back-to-back frame: no idle cycle between handshake and accumulation.
              state_reg <= ACCUM;
              row_reg   <= '0;
              col_reg   <= '0;
              acc_reg   <= '0;
`ifdef TRACE_SAT_EN
              sat_acc_reg <= 1'b0;
`endif
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_acc.sv
module tb_trace_acc;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int OW = 16;

  localparam int DW2 = 8;
  localparam int N2  = 3;
  localparam int OW2 = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          sat;

  logic           start2 = 1'b0;
  logic           clr2 = 1'b0;
  logic           in_valid2 = 1'b0;
  logic           in_ready2;
  logic [DW2-1:0] in_data2 = '0;
  logic           out_valid2;
  logic           out_ready2 = 1'b1;
  logic [OW2-1:0] out_data2;
  logic           busy2;
  logic           sat2;

  int checks   = 0;
  int failures = 0;

  logic [OW:0]  exp_q[$];
  logic [OW2:0] exp2_q[$];
  logic [OW:0]  e1;
  logic [OW2:0] e2;

  always #5 clk = ~clk;

  trace_acc #(.DW(DW), .N(N), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .sat(sat)
  );

  trace_acc #(.DW(DW2), .N(N2), .OW(OW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .clr(clr2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2), .sat(sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop: a handshake will occur at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_data), 32'hDEAD);
      end else begin
        e1 = exp_q.pop_front();
        $display("txn N=4 out_data=%0h sat=%0b expected=%0h/%0b", out_data, sat, e1[OW-1:0], e1[OW]);
        chk("trace_data", 32'(out_data), 32'(e1[OW-1:0]));
        chk("trace_sat", 32'(sat), 32'(e1[OW]));
      end
    end
    if (rst_n && out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) begin
        chk("unexpected_result2", 32'(out_data2), 32'hDEAD);
      end else begin
        e2 = exp2_q.pop_front();
        $display("txn N=3 out_data=%0h sat=%0b expected=%0h/%0b", out_data2, sat2, e2[OW2-1:0], e2[OW2]);
        chk("trace_data_n3", 32'(out_data2), 32'(e2[OW2-1:0]));
        chk("trace_sat_n3", 32'(sat2), 32'(e2[OW2]));
      end
    end
  end

  // Drive one frame (or its first nelem elements) into the N=4 instance.
  // d holds diagonal values, element r at d[r*DW +: DW].
  task automatic send_frame(input logic [N*DW-1:0] d, input logic [DW-1:0] off,
                            input int gapmax, input bit do_start, input bit spam,
                            input int nelem);
    if (do_start) begin
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int k = 0; k < nelem; k++) begin
      int r;
      int c;
      r = k / N;
      c = k % N;
      if (gapmax > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, gapmax)) begin
          chk("gap_in_ready", 32'(in_ready), 32'd1);
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = (r == c) ? d[r*DW +: DW] : off;
      start    = spam && (r != c);
      if (k == N*N-1) chk("pre_last_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (nelem == N*N) chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_out_valid_n3", 32'(out_valid2), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic trace, off-diagonal large values must be ignored.
    exp_q.push_back({1'b0, 16'd10});
    send_frame({16'd4, 16'd3, 16'd2, 16'd1}, 16'h7FFF, 0, 1'b1, 1'b0, N*N);
    step(); step();

    // Negative diagonal with random input gaps.
    exp_q.push_back({1'b0, 16'hFFF8});
    send_frame({16'd1, 16'hFFF9, 16'd3, 16'hFFFB}, 16'h1234, 3, 1'b1, 1'b0, N*N);
    step(); step();
    chk("idle_after_frame_busy", 32'(busy), 32'd0);

    // Back-pressure, ignored start pulses, then start-with-handshake handoff.
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'd8});
    send_frame({16'd2, 16'd2, 16'd2, 16'd2}, 16'd1, 0, 1'b1, 1'b1, N*N);
    start = 1'b1;
    repeat (5) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'd8);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    exp_q.push_back({1'b0, 16'd10});
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    chk("handoff_out_valid", 32'(out_valid), 32'd0);
    send_frame({16'd4, 16'd3, 16'd2, 16'd1}, 16'd7, 0, 1'b0, 1'b0, N*N);
    step(); step();

    // Asynchronous reset mid-frame, mid-cycle.
    send_frame({16'd9, 16'd9, 16'd9, 16'd9}, 16'd3, 0, 1'b1, 1'b0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    chk("async_rst_sat", 32'(sat), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    exp_q.push_back({1'b0, 16'd4});
    send_frame({16'd1, 16'd1, 16'd1, 16'd1}, 16'd5, 0, 1'b1, 1'b0, N*N);
    step(); step();

    // clr abort after 9 elements, then a fresh frame.
    send_frame({16'd50, 16'd50, 16'd50, 16'd50}, 16'd2, 0, 1'b1, 1'b0, 9);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_out_data_kept", 32'(out_data), 32'd4);
    exp_q.push_back({1'b0, 16'd3});
    send_frame({16'd0, 16'd0, 16'd0, 16'd3}, 16'd9, 0, 1'b1, 1'b0, N*N);
    step(); step();

    // Overflow behaviour.
`ifdef TRACE_SAT_EN
    exp_q.push_back({1'b1, 16'h7FFF});
`else
    exp_q.push_back({1'b0, 16'hE000});
`endif
    send_frame({16'd0, 16'd0, 16'h7000, 16'h7000}, 16'd1, 0, 1'b1, 1'b0, N*N);
    step(); step();
`ifdef TRACE_SAT_EN
    exp_q.push_back({1'b1, 16'h8000});
`else
    exp_q.push_back({1'b0, 16'h0000});
`endif
    send_frame({16'd0, 16'd0, 16'h8000, 16'h8000}, 16'd1, 0, 1'b1, 1'b0, N*N);
    step(); step();
    // sat must clear on the next frame.
    exp_q.push_back({1'b0, 16'd6});
    send_frame({16'd3, 16'd0, 16'd2, 16'd1}, 16'd1, 0, 1'b1, 1'b0, N*N);
    step(); step();

    // N=3, DW=8, OW=12 instance.
    exp2_q.push_back({1'b0, 12'd300});
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int k = 0; k < N2*N2; k++) begin
      in_valid2 = 1'b1;
      in_data2  = ((k / N2) == (k % N2)) ? 8'd100 : 8'h55;
      step();
    end
    in_valid2 = 1'b0;
    chk("latency_out_valid_n3", 32'(out_valid2), 32'd1);
    step(); step();

    for (int t = 0; t < 20 && (exp_q.size() != 0 || exp2_q.size() != 0); t++) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("scoreboard_drained_n3", 32'(exp2_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
